gpio_int_ctrl: RTL
==================

GPIO_INT_CTRL -- requirements
Module: gpio_int_ctrl

Parameters
REQ-001 Parameter NUM_GPIOS, default 32, GPIO pin count; multiple of 8, range 8..32.
REQ-002 Parameter NUM_INTX, default 8, external interrupt source count; range 1..32.
REQ-003 Parameter ADDR_BITS, default 12, register address width.
REQ-004 Parameter BASE_ADDR, default 0, word address of register 0; the block decodes BASE_ADDR..BASE_ADDR+7.

Interface
REQ-005 clk  in  1  clock; all logic is rising-edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 sync_reset  in  1  synchronous reset, active-high.
REQ-008 WB_RD_STB_I  in  1  read strobe.
REQ-009 WB_RD_ADR_I  in  ADDR_BITS  read word address.
REQ-010 WB_RD_DAT_O  out  32  read data.
REQ-011 WB_RD_ACK_O  out  1  read acknowledge.
REQ-012 WB_WR_STB_I, WB_WR_WE_I  in  1 each  write strobe, write enable.
REQ-013 WB_WR_SEL_I  in  4  byte lane select.
REQ-014 WB_WR_ADR_I  in  ADDR_BITS  write word address.
REQ-015 WB_WR_DAT_I  in  32  write data.
REQ-016 WB_WR_ACK_O  out  1  write acknowledge.
REQ-017 gpio_in  in  NUM_GPIOS  asynchronous pin inputs.
REQ-018 gpio_out, gpio_oe  out  NUM_GPIOS  pin drive value, pin output enable.
REQ-019 INTx  in  NUM_INTX  asynchronous interrupt inputs.
REQ-020 int_gen  out  1  registered interrupt request to the core.

Function
REQ-021 Register offsets from BASE_ADDR: 0 GPIO_OUT (RW), 1 GPIO_OE (RW), 2 GPIO_IN (RO), 3 INT_EN (RW), 4 INT_TYPE (RW, 1 = edge, 0 = level), 5 INT_POL (RW, 1 = rising/high, 0 = falling/low), 6 INT_PEND (read; write-1-to-clear), 7 INT_STAT (RO, INT_PEND & INT_EN).
REQ-022 A write takes effect when WB_WR_STB_I and WB_WR_WE_I are both high at a decoded address.
REQ-023 For a write, only byte lanes with WB_WR_SEL_I[k] = 1 update; this applies to every RW register and to the INT_PEND clear mask.
REQ-024 WB_WR_ACK_O is asserted exactly 1 cycle after any write strobe, decoded or not.
REQ-025 WB_RD_ACK_O and WB_RD_DAT_O are registered, valid 1 cycle after WB_RD_STB_I.
REQ-026 Unused upper bits and unmapped addresses read 0.
REQ-027 gpio_in and INTx each pass a 2-flop synchronizer; GPIO_IN returns the second-stage value.
REQ-028 Each source has a prev-stage flop on its synchronized value for edge detection.
REQ-029 Edge mode: pending bit sets on the selected edge and holds until cleared by W1C.
REQ-030 Level mode: pending bit equals (synced level == INT_POL) each cycle; W1C has no effect.
REQ-031 Same-cycle edge detect and W1C on one bit: set wins, pending stays 1.
REQ-032 Changing INT_TYPE or INT_POL does not clear pending; it produces no spurious edge, because edge detection uses synced/prev values only.
REQ-033 int_gen <= |(INT_PEND & INT_EN), registered, so latency from INTx pin to int_gen is 4 cycles.
REQ-034 A read has no side effects.
REQ-035 Read and write at the same address in the same cycle: read returns the pre-write value.

Reset
REQ-036 On reset_n low, all registers, synchronizer flops, acks, WB_RD_DAT_O and int_gen reset to 0 asynchronously; gpio_oe = 0, so all pins are inputs.
REQ-037 sync_reset high clears the same state on the next edge; it has priority over a concurrent write.
REQ-038 Reset during a pending interrupt drops int_gen within 1 cycle of sync_reset, or immediately on reset_n.

Structure
REQ-039 Register offsets, the INT_TYPE/INT_POL encodings and the ack latency constant live in package gpio_int_pkg.
REQ-040 Per-source sync, edge detection and pending logic is one sub-module, int_src_cell, instantiated NUM_INTX times via generate.

Verification
REQ-041 Write 0xA5A5_00FF to GPIO_OUT with SEL = 4'b0001 -> gpio_out = 0x0000_00FF; WB_WR_ACK_O high the next cycle.
REQ-042 Drive gpio_in = 0x1234_5678 -> read GPIO_IN returns 0x1234_5678 when the read strobe is at least 2 cycles after the pin change; read ack 1 cycle after the strobe.
REQ-043 INT_TYPE[2] = 1, INT_POL[2] = 1, INT_EN = 0x4, pulse INTx[2] for 1 cycle -> INT_PEND = 0x4 and int_gen = 1 four cycles after the pulse; write INT_PEND 0x4 -> int_gen = 0 two cycles later.
REQ-044 Level mode, INT_POL[0] = 0, INTx[0] held low -> pending stays 1 after a W1C; release INTx[0] -> pending = 0 three cycles later.
REQ-045 W1C on bit 1 in the same cycle as a detected rising edge on bit 1 -> INT_PEND[1] remains 1.
REQ-046 Assert reset_n low mid-operation with int_gen = 1 -> int_gen, gpio_oe and INT_PEND are 0 immediately.

Source files
------------

// File: rtl/gpio_int_pkg.sv
// Shared register map, interrupt encodings and bus timing constants for the
// GPIO / interrupt controller.
package gpio_int_pkg;

  typedef enum logic [2:0] {
    REG_GPIO_OUT = 3'd0,
    REG_GPIO_OE  = 3'd1,
    REG_GPIO_IN  = 3'd2,
    REG_INT_EN   = 3'd3,
    REG_INT_TYPE = 3'd4,
    REG_INT_POL  = 3'd5,
    REG_INT_PEND = 3'd6,
    REG_INT_STAT = 3'd7
  } reg_off_e;

  typedef enum logic {
    INT_LEVEL = 1'b0,
    INT_EDGE  = 1'b1
  } int_type_e;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } int_pol_e;

  localparam int unsigned WR_ACK_LATENCY = 1;

  // Expands the 4-bit byte-lane select into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/int_src_cell.sv
// One interrupt source: 2-flop synchronizer, previous-value flop for edge
// detection, and the pending bit in either edge (sticky, W1C) or level mode.
module int_src_cell
  import gpio_int_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic sync_reset,
  input  logic int_i,
  input  logic type_i,
  input  logic pol_i,
  input  logic clr_i,
  output logic pend_o
);

  logic sync1_q, sync2_q, prev_q;
  logic pend_q, pend_d;
  logic edge_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else if (sync_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync1_q <= int_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
    end
  end

  // A detected edge is OR-ed in after the clear so a same-cycle W1C loses.
  always_comb begin
    edge_hit = (pol_i == POL_HIGH) ? (sync2_q & ~prev_q) : (~sync2_q & prev_q);
    pend_d   = pend_q;
    if (type_i == INT_EDGE) begin
      pend_d = edge_hit | (pend_q & ~clr_i);
    end else begin
      pend_d = (sync2_q == pol_i);
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/gpio_int_ctrl.sv
// GPIO and external interrupt controller with separate Wishbone-style read
// and write ports and an eight-word register window at BASE_ADDR.
module gpio_int_ctrl
  import gpio_int_pkg::*;
#(
  parameter int NUM_GPIOS = 32,
  parameter int NUM_INTX  = 8,
  parameter int ADDR_BITS = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic                 WB_RD_STB_I,
  input  logic [ADDR_BITS-1:0] WB_RD_ADR_I,
  output logic [31:0]          WB_RD_DAT_O,
  output logic                 WB_RD_ACK_O,
  input  logic                 WB_WR_STB_I,
  input  logic                 WB_WR_WE_I,
  input  logic [3:0]           WB_WR_SEL_I,
  input  logic [ADDR_BITS-1:0] WB_WR_ADR_I,
  input  logic [31:0]          WB_WR_DAT_I,
  output logic                 WB_WR_ACK_O,
  input  logic [NUM_GPIOS-1:0] gpio_in,
  output logic [NUM_GPIOS-1:0] gpio_out,
  output logic [NUM_GPIOS-1:0] gpio_oe,
  input  logic [NUM_INTX-1:0]  INTx,
  output logic                 int_gen
);

  localparam logic [ADDR_BITS-1:0] BASE = ADDR_BITS'(BASE_ADDR);

  logic [NUM_GPIOS-1:0] out_q, out_d, oe_q, oe_d;
  logic [NUM_GPIOS-1:0] gin1_q, gin2_q;
  logic [NUM_INTX-1:0]  en_q, en_d, type_q, type_d, pol_q, pol_d;
  logic [NUM_INTX-1:0]  pend_clr, int_pend;
  logic [WR_ACK_LATENCY-1:0] wr_ack_q;
  logic                 rd_ack_q, int_gen_q;
  logic [31:0]          rd_dat_q, rd_data;

  logic [ADDR_BITS-1:0] rd_off, wr_off;
  logic                 rd_hit, wr_hit, wr_en;
  reg_off_e             rd_sel, wr_sel;
  logic [31:0]          lane;
  logic [NUM_GPIOS-1:0] g_mask, g_dat;
  logic [NUM_INTX-1:0]  i_mask, i_dat;

  // Offsets wrap modulo 2^ADDR_BITS, so one unsigned compare bounds the window.
  assign rd_off = WB_RD_ADR_I - BASE;
  assign wr_off = WB_WR_ADR_I - BASE;
  assign rd_hit = rd_off < ADDR_BITS'(8);
  assign wr_hit = wr_off < ADDR_BITS'(8);
  assign rd_sel = reg_off_e'(rd_off[2:0]);
  assign wr_sel = reg_off_e'(wr_off[2:0]);
  assign wr_en  = WB_WR_STB_I & WB_WR_WE_I & wr_hit;

  assign lane   = lane_mask(WB_WR_SEL_I);
  assign g_mask = lane[NUM_GPIOS-1:0];
  assign g_dat  = WB_WR_DAT_I[NUM_GPIOS-1:0];
  assign i_mask = lane[NUM_INTX-1:0];
  assign i_dat  = WB_WR_DAT_I[NUM_INTX-1:0];

  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    en_d     = en_q;
    type_d   = type_q;
    pol_d    = pol_q;
    pend_clr = '0;
    if (wr_en) begin
      case (wr_sel)
        REG_GPIO_OUT: out_d    = (out_q  & ~g_mask) | (g_dat & g_mask);
        REG_GPIO_OE:  oe_d     = (oe_q   & ~g_mask) | (g_dat & g_mask);
        REG_INT_EN:   en_d     = (en_q   & ~i_mask) | (i_dat & i_mask);
        REG_INT_TYPE: type_d   = (type_q & ~i_mask) | (i_dat & i_mask);
        REG_INT_POL:  pol_d    = (pol_q  & ~i_mask) | (i_dat & i_mask);
        REG_INT_PEND: pend_clr = i_dat & i_mask;
        default: ;
      endcase
    end
  end

  // Read mux sees only current register state, so a same-cycle write is not visible.
  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      case (rd_sel)
        REG_GPIO_OUT: rd_data = 32'(out_q);
        REG_GPIO_OE:  rd_data = 32'(oe_q);
        REG_GPIO_IN:  rd_data = 32'(gin2_q);
        REG_INT_EN:   rd_data = 32'(en_q);
        REG_INT_TYPE: rd_data = 32'(type_q);
        REG_INT_POL:  rd_data = 32'(pol_q);
        REG_INT_PEND: rd_data = 32'(int_pend);
        REG_INT_STAT: rd_data = 32'(int_pend & en_q);
        default:      rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      oe_q      <= '0;
      en_q      <= '0;
      type_q    <= '0;
      pol_q     <= '0;
      gin1_q    <= '0;
      gin2_q    <= '0;
      wr_ack_q  <= '0;
      rd_ack_q  <= 1'b0;
      rd_dat_q  <= '0;
      int_gen_q <= 1'b0;
    end else if (sync_reset) begin
      out_q     <= '0;
      oe_q      <= '0;
      en_q      <= '0;
      type_q    <= '0;
      pol_q     <= '0;
      gin1_q    <= '0;
      gin2_q    <= '0;
      wr_ack_q  <= '0;
      rd_ack_q  <= 1'b0;
      rd_dat_q  <= '0;
      int_gen_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      en_q      <= en_d;
      type_q    <= type_d;
      pol_q     <= pol_d;
      gin1_q    <= gpio_in;
      gin2_q    <= gin1_q;
      wr_ack_q  <= (wr_ack_q << 1) | WR_ACK_LATENCY'(WB_WR_STB_I);
      rd_ack_q  <= WB_RD_STB_I;
      rd_dat_q  <= WB_RD_STB_I ? rd_data : '0;
      int_gen_q <= |(int_pend & en_q);
    end
  end

  for (genvar i = 0; i < NUM_INTX; i++) begin : g_src
    int_src_cell u_cell (
      .clk       (clk),
      .reset_n   (reset_n),
      .sync_reset(sync_reset),
      .int_i     (INTx[i]),
      .type_i    (type_q[i]),
      .pol_i     (pol_q[i]),
      .clr_i     (pend_clr[i]),
      .pend_o    (int_pend[i])
    );
  end

  assign gpio_out    = out_q;
  assign gpio_oe     = oe_q;
  assign WB_RD_DAT_O = rd_dat_q;
  assign WB_RD_ACK_O = rd_ack_q;
  assign WB_WR_ACK_O = wr_ack_q[WR_ACK_LATENCY-1];
  assign int_gen     = int_gen_q;

endmodule
